// File: rtl/bram_arb_pkg.sv
// Shared widths and types for the two-client BRAM port arbiter.
package bram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned PAR_W_DEF  = 2;

    typedef enum logic {
        CLIENT0 = 1'b0,
        CLIENT1 = 1'b1
    } client_id_t;

    // One entry of the read-return tag pipeline
    typedef struct packed {
        logic       valid;
        client_id_t id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grants, registered pointer.
module rr_arbiter2
    import bram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0_c,
    output logic gnt1_c
);

    client_id_t ptr;

    // A lone requester wins outright; the pointer only breaks ties
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!rst) begin
            if (req0 && (!req1 || ptr == CLIENT0)) begin
                gnt0_c = 1'b1;
            end else if (req1) begin
                gnt1_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= CLIENT0;
        end else if (gnt0_c) begin
            ptr <= CLIENT1;
        end else if (gnt1_c) begin
            ptr <= CLIENT0;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one synchronous RAM port between two clients; read data returns
// two cycles after accept, tagged with the requesting client.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PAR_W  = PAR_W_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      REQ0,
    input  logic                      REQ1,
    input  logic                      WE0,
    input  logic                      WE1,
    input  logic [ADDR_W-1:0]         ADDR0,
    input  logic [ADDR_W-1:0]         ADDR1,
    input  logic [DATA_W+PAR_W-1:0]   WDATA0,
    input  logic [DATA_W+PAR_W-1:0]   WDATA1,
    output logic                      GNT0,
    output logic                      GNT1,
    output logic                      RVALID0,
    output logic                      RVALID1,
    output logic [DATA_W+PAR_W-1:0]   RDATA,
    output logic                      RAM_EN,
    output logic                      RAM_WE,
    output logic [ADDR_W-1:0]         RAM_ADDR,
    output logic [DATA_W-1:0]         RAM_DI,
    output logic [PAR_W-1:0]          RAM_DIP,
    input  logic [DATA_W-1:0]         RAM_DO,
    input  logic [PAR_W-1:0]          RAM_DOP
);

    localparam int unsigned WORD_W = DATA_W + PAR_W;

    logic              accept_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [WORD_W-1:0] sel_wdata_c;
    tag_t              tag_s1;

    rr_arbiter2 u_arb (
        .clk    (CLK),
        .rst    (RST),
        .req0   (REQ0),
        .req1   (REQ1),
        .gnt0_c (GNT0),
        .gnt1_c (GNT1)
    );

    // Grants are one-hot, so GNT1 alone steers the request mux
    always_comb begin
        accept_c    = GNT0 | GNT1;
        sel_we_c    = GNT1 ? WE1    : WE0;
        sel_addr_c  = GNT1 ? ADDR1  : ADDR0;
        sel_wdata_c = GNT1 ? WDATA1 : WDATA0;
    end

    // Stage 1 tag rides with the RAM command; stage 2 is kept decoded as RVALIDx
    always_ff @(posedge CLK) begin
        if (RST) begin
            RAM_EN   <= 1'b0;
            RAM_WE   <= 1'b0;
            RAM_ADDR <= '0;
            RAM_DI   <= '0;
            RAM_DIP  <= '0;
            tag_s1   <= '0;
            RVALID0  <= 1'b0;
            RVALID1  <= 1'b0;
        end else begin
            RAM_EN <= accept_c;
            RAM_WE <= accept_c & sel_we_c;
            if (accept_c) begin
                RAM_ADDR <= sel_addr_c;
                RAM_DI   <= sel_wdata_c[DATA_W-1:0];
                RAM_DIP  <= sel_wdata_c[WORD_W-1:DATA_W];
            end
            tag_s1.valid <= accept_c & ~sel_we_c;
            tag_s1.id    <= client_id_t'(GNT1);
            RVALID0      <= tag_s1.valid && (tag_s1.id == CLIENT0);
            RVALID1      <= tag_s1.valid && (tag_s1.id == CLIENT1);
        end
    end

    assign RDATA = {RAM_DOP, RAM_DO};

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural RAM, cycle-accurate scoreboard
// monitor on the falling edge, directed scenarios then random traffic.
module tb_bram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int PW = 2;
    localparam int WW = DW + PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [WW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [WW-1:0] rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_do;
    logic [PW-1:0] ram_dip, ram_dop;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PAR_W(PW)) dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
        .GNT0(gnt0), .GNT1(gnt1), .RVALID0(rvalid0), .RVALID1(rvalid1),
        .RDATA(rdata), .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_ADDR(ram_addr),
        .RAM_DI(ram_di), .RAM_DIP(ram_dip), .RAM_DO(ram_do), .RAM_DOP(ram_dop)
    );

    logic [WW-1:0] mem     [1024];
    logic [WW-1:0] ref_mem [1024];

    // Synchronous RAM, one cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= {ram_dip, ram_di};
            else        {ram_dop, ram_do} <= mem[ram_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        logic          cl;
        logic [WW-1:0] data;
    } rd_t;
    rd_t sbq[$];

    logic          mptr  = 1'b0;
    logic          e_en  = 1'b0;
    logic          e_we  = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [WW-1:0] e_di   = '0;
    logic          e_gnt0, e_gnt1, s_we;
    logic [AW-1:0] s_addr;
    logic [WW-1:0] s_wd;

    // Reference model of grants, RAM command registers and read returns
    always @(negedge clk) begin
        cyc++;
        e_gnt0 = !rst && req0 && (!req1 || !mptr);
        e_gnt1 = !rst && req1 && !e_gnt0;
        chk("gnt0", 32'(gnt0), 32'(e_gnt0));
        chk("gnt1", 32'(gnt1), 32'(e_gnt1));
        chk("ram_en", 32'(ram_en), 32'(e_en));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_di", 32'({ram_dip, ram_di}), 32'(e_di));
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            chk("sb_rvalid0", 32'(rvalid0), 32'(!sbq[0].cl));
            chk("sb_rvalid1", 32'(rvalid1), 32'(sbq[0].cl));
            chk("sb_rdata", 32'(rdata), 32'(sbq[0].data));
            void'(sbq.pop_front());
        end else begin
            chk("idle_rvalid0", 32'(rvalid0), 32'(0));
            chk("idle_rvalid1", 32'(rvalid1), 32'(0));
        end
        if (rst) begin
            sbq.delete();
            mptr = 1'b0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_di = '0;
        end else if (e_gnt0 || e_gnt1) begin
            s_we   = e_gnt1 ? we1    : we0;
            s_addr = e_gnt1 ? addr1  : addr0;
            s_wd   = e_gnt1 ? wdata1 : wdata0;
            e_en = 1'b1; e_we = s_we; e_addr = s_addr; e_di = s_wd;
            if (s_we) ref_mem[s_addr] = s_wd;
            else      sbq.push_back('{due: cyc + 2, cl: e_gnt1, data: ref_mem[s_addr]});
            mptr = e_gnt0;
        end else begin
            e_en = 1'b0; e_we = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = WW'(i * 37 + 5);
            ref_mem[i] = WW'(i * 37 + 5);
        end
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Grants suppressed while in reset, reset values afterwards
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'(0));
        chk("rst_gnt1", 32'(gnt1), 32'(0));
        tick(); req0 = 1'b0; req1 = 1'b0;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_ram_en", 32'(ram_en), 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_ram_di", 32'({ram_dip, ram_di}), 32'(0));

        // Single write from client 0
        tick(); req0 = 1'b1; we0 = 1'b1; addr0 = 10'h005; wdata0 = 18'h1ABCD;
        @(negedge clk); chk("w_gnt0", 32'(gnt0), 32'(1));
        tick(); req0 = 1'b0;
        @(negedge clk);
        chk("w_ram_en", 32'(ram_en), 32'(1));
        chk("w_ram_we", 32'(ram_we), 32'(1));
        chk("w_ram_addr", 32'(ram_addr), 32'h005);
        chk("w_ram_dip", 32'(ram_dip), 32'(2'b01));
        chk("w_ram_di", 32'(ram_di), 32'hABCD);

        // Client 1 reads it back two cycles later
        tick(); req1 = 1'b1; we1 = 1'b0; addr1 = 10'h005;
        @(negedge clk); chk("r_gnt1", 32'(gnt1), 32'(1));
        tick(); req1 = 1'b0;
        @(negedge clk); chk("r_rvalid1_early", 32'(rvalid1), 32'(0));
        tick();
        @(negedge clk);
        chk("r_rvalid1", 32'(rvalid1), 32'(1));
        chk("r_rdata", 32'(rdata), 32'h1ABCD);
        chk("r_rvalid0", 32'(rvalid0), 32'(0));

        // Lone request from client 1 right after a client-1 grant
        tick(); req1 = 1'b1; addr1 = 10'h007;
        @(negedge clk); chk("single_gnt1", 32'(gnt1), 32'(1));
        tick(); req1 = 1'b0;

        // Both requesting from reset: alternate 0,1,0,1
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 10'h010; addr1 = 10'h3FF; wdata0 = 18'h21111; wdata1 = 18'h3FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt0", 32'(gnt0), 32'(i % 2 == 0));
            chk("rr_gnt1", 32'(gnt1), 32'(i % 2 == 1));
            if (i > 0) chk("rr_addr", 32'(ram_addr), (i % 2 == 1) ? 32'h010 : 32'h3FF);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        @(negedge clk); chk("rr_addr_last", 32'(ram_addr), 32'h3FF);

        // Back-to-back reads 0,1,0 return in order
        tick(); req0 = 1'b1; addr0 = 10'h010;
        @(negedge clk);
        tick(); req0 = 1'b0; req1 = 1'b1; addr1 = 10'h3FF;
        @(negedge clk);
        tick(); req1 = 1'b0; req0 = 1'b1; addr0 = 10'h020;
        @(negedge clk);
        chk("b2b_rv0_a", 32'(rvalid0), 32'(1));
        chk("b2b_rdata_a", 32'(rdata), 32'h21111);
        tick(); req0 = 1'b0;
        @(negedge clk);
        chk("b2b_rv1_b", 32'(rvalid1), 32'(1));
        chk("b2b_rdata_b", 32'(rdata), 32'h3FFFF);
        tick();
        @(negedge clk);
        chk("b2b_rv0_c", 32'(rvalid0), 32'(1));
        chk("b2b_rdata_c", 32'(rdata), 32'(WW'(32'h20 * 37 + 5)));

        // Reset right after a read accept discards the return
        tick(); req0 = 1'b1; addr0 = 10'h003;
        @(negedge clk);
        tick(); req0 = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("flush_rv0", 32'(rvalid0), 32'(0));
        chk("flush_rv1", 32'(rvalid1), 32'(0));
        chk("flush_ram_en", 32'(ram_en), 32'(0));
        tick(); req0 = 1'b1; req1 = 1'b1; addr0 = 10'h001; addr1 = 10'h002;
        @(negedge clk); chk("ptr_after_rst", 32'(gnt0), 32'(1));
        tick(); req0 = 1'b0; req1 = 1'b0;

        // Random traffic, checked entirely by the monitor
        repeat (300) begin
            tick();
            rst    = ($urandom_range(0, 49) == 0);
            req0   = 1'($urandom_range(0, 1));
            req1   = 1'($urandom_range(0, 1));
            we0    = ($urandom_range(0, 2) == 0);
            we1    = ($urandom_range(0, 2) == 0);
            addr0  = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
            addr1  = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
            wdata0 = WW'($urandom);
            wdata1 = WW'($urandom);
        end
        tick(); rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();
        chk("sb_drained", 32'(sbq.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
